// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB memory completer family.
//   - apb_slv_state_t : completer FSM state encoding (IDLE / WAIT / DONE)
//   - APB_CNT_W       : width of the wait-state counter (WAIT_STATES 0..15)
//   - APB_ERR_NONE / APB_ERR_ADDR : PSLVERR values, usable by benches too
//   - apb_byte_sh / apb_strb_w / apb_idx_w : geometry helpers derived from
//     the data width and memory depth
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_slv_state_t;

    localparam int APB_CNT_W = 4;

    localparam logic APB_ERR_NONE = 1'b0;
    localparam logic APB_ERR_ADDR = 1'b1;

    // Number of byte-offset bits inside one data word.
    function automatic int apb_byte_sh(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of byte lanes (PSTRB width).
    function automatic int apb_strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // Word-index width for a memory of the given depth (at least one bit).
    function automatic int apb_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// -----------------------------------------------------------------------------
// apb_mem_slave_if
// APB4 bus bundle between the bridge (master) and one memory completer.
//   PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB : driven by the master
//   PRDATA, PREADY, PSLVERR                     : driven by the completer
// PCLK and PRESET stay plain module ports and are not part of the bundle.
// -----------------------------------------------------------------------------
interface apb_mem_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);

    logic                  PSEL;
    logic [ADDR_W-1:0]     PADDR;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_sram_bank.sv
// -----------------------------------------------------------------------------
// apb_sram_bank
// Word-organised register-file memory with per-byte write enables.
// Kept apart from the bus FSM so it can later be replaced by an SRAM macro.
//   clk   : write clock (rising edge)
//   we    : write enable for this cycle
//   waddr : word index to write (must be < DEPTH when we=1)
//   wdata : write data
//   wstrb : byte-lane enables; lane k covers wdata[8k+7:8k]
//   raddr : word index to read
//   rdata : combinational read data (zero for indices beyond DEPTH)
// Contents are not reset.
// -----------------------------------------------------------------------------
module apb_sram_bank
    import apb_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int IDX_W  = apb_idx_w(DEPTH),
    localparam int STRB_W = apb_strb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write: only lanes with their strobe set are updated, so a
    // write with all strobes low leaves the word untouched.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
        end
    end

    // A non-power-of-two depth leaves index codes with no backing word;
    // those read as zero instead of indexing past the array.
    if ((1 << IDX_W) == DEPTH) begin : g_full_read
        assign rdata = mem[raddr];
    end else begin : g_guarded_read
        assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
    end

endmodule

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
// APB4 completer in front of a byte-enabled word memory, with configurable
// data width, depth and number of wait states, PSTRB byte strobes and a
// PSLVERR response for out-of-range or misaligned addresses.
//   PCLK   : bus clock, all state changes on the rising edge
//   PRESET : active-low reset, asynchronous assert
//   bus    : APB slave modport (PSEL/PADDR/PENABLE/PWRITE/PWDATA/PSTRB in,
//            PRDATA/PREADY/PSLVERR out; all outputs registered)
// Parameters: ADDR_W (byte address width), DATA_W (8/16/32/64),
//             DEPTH (words, any value), WAIT_STATES (0..15).
// -----------------------------------------------------------------------------
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_mem_slave_if.slave bus
);

    localparam int BYTE_SH = apb_byte_sh(DATA_W);
    localparam int STRB_W  = apb_strb_w(DATA_W);
    localparam int IDX_W   = apb_idx_w(DEPTH);
    localparam int CMP_W   = ADDR_W + 32;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << BYTE_SH) - 1);

    apb_slv_state_t        state;
    logic [APB_CNT_W-1:0]  cnt;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_W-1:0]     prdata_q;

    logic                  wr_pend;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_W-1:0]     wr_data;
    logic [STRB_W-1:0]     wr_strb;

    logic [ADDR_W-1:0]     word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  misaligned;
    logic                  range_err;
    logic                  addr_err;
    logic                  setup_phase;
    logic                  enter_done;
    logic                  commit;
    logic [DATA_W-1:0]     rd_data;

    // Address decode. The full PADDR width takes part in the range check so
    // that high addresses never alias onto low words.
    assign word_idx    = bus.PADDR >> BYTE_SH;
    assign mem_idx     = IDX_W'(word_idx);
    assign misaligned  = |(bus.PADDR & LANE_MASK);
    assign range_err   = CMP_W'(word_idx) >= CMP_W'(DEPTH);
    assign addr_err    = misaligned | range_err;
    assign setup_phase = bus.PSEL & ~bus.PENABLE;

    // A write is latched on DONE entry and committed on the edge that leaves
    // DONE, so the word is updated before any following transfer samples it.
    assign commit = (state == DONE) & wr_pend;

    // Decide whether this edge enters DONE: either a setup with no wait
    // states, or the last wait-state cycle of an access that is still selected.
    always_comb begin
        enter_done = 1'b0;
        case (state)
            IDLE, DONE: enter_done = setup_phase && (WAIT_STATES == 0);
            WAIT:       enter_done = bus.PSEL && bus.PENABLE && (cnt <= APB_CNT_W'(1));
            default:    enter_done = 1'b0;
        endcase
    end

    // Completer FSM with registered PREADY/PSLVERR/PRDATA. Outputs are loaded
    // only on the edge entering DONE and cleared on every other edge, which
    // gives exactly one PREADY cycle per transfer. Dropping PSEL during WAIT
    // abandons the transfer without touching memory.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_pend   <= 1'b0;
            wr_idx    <= '0;
            wr_data   <= '0;
            wr_strb   <= '0;
        end else begin
            pready_q  <= enter_done;
            pslverr_q <= enter_done & addr_err;
            prdata_q  <= (enter_done & ~bus.PWRITE & ~addr_err) ? rd_data : '0;
            wr_pend   <= enter_done & bus.PWRITE & ~addr_err;
            if (enter_done) begin
                wr_idx  <= mem_idx;
                wr_data <= bus.PWDATA;
                wr_strb <= bus.PSTRB;
            end

            case (state)
                IDLE, DONE: begin
                    if (setup_phase) begin
                        cnt   <= APB_CNT_W'(WAIT_STATES);
                        state <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (!bus.PSEL) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (bus.PENABLE) begin
                        if (cnt <= APB_CNT_W'(1)) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_sram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (PCLK),
        .we    (commit),
        .waddr (wr_idx),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .raddr (mem_idx),
        .rdata (rd_data)
    );

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
// Directed bench for apb_mem_slave. Three instances share one set of bus
// drive signals, each with its own PSEL:
//   index 0 : WAIT_STATES = 0
//   index 1 : WAIT_STATES = 3
//   index 2 : WAIT_STATES = 2
// All use ADDR_W=8, DATA_W=32, DEPTH=32. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;
    import apb_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic        pclk;
    logic        preset_n;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [2:0]  rdy_v;
    logic [2:0]  err_v;
    logic [31:0] rdata_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    apb_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_ws0 ();
    apb_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_ws3 ();
    apb_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_ws2 ();

    assign bus_ws0.PSEL    = psel_v[0];
    assign bus_ws0.PADDR   = paddr;
    assign bus_ws0.PENABLE = penable;
    assign bus_ws0.PWRITE  = pwrite;
    assign bus_ws0.PWDATA  = pwdata;
    assign bus_ws0.PSTRB   = pstrb;

    assign bus_ws3.PSEL    = psel_v[1];
    assign bus_ws3.PADDR   = paddr;
    assign bus_ws3.PENABLE = penable;
    assign bus_ws3.PWRITE  = pwrite;
    assign bus_ws3.PWDATA  = pwdata;
    assign bus_ws3.PSTRB   = pstrb;

    assign bus_ws2.PSEL    = psel_v[2];
    assign bus_ws2.PADDR   = paddr;
    assign bus_ws2.PENABLE = penable;
    assign bus_ws2.PWRITE  = pwrite;
    assign bus_ws2.PWDATA  = pwdata;
    assign bus_ws2.PSTRB   = pstrb;

    assign rdy_v      = {bus_ws2.PREADY, bus_ws3.PREADY, bus_ws0.PREADY};
    assign err_v      = {bus_ws2.PSLVERR, bus_ws3.PSLVERR, bus_ws0.PSLVERR};
    assign rdata_v[0] = bus_ws0.PRDATA;
    assign rdata_v[1] = bus_ws3.PRDATA;
    assign rdata_v[2] = bus_ws2.PRDATA;

    apb_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .PCLK   (pclk),
        .PRESET (preset_n),
        .bus    (bus_ws0)
    );

    apb_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .PCLK   (pclk),
        .PRESET (preset_n),
        .bus    (bus_ws3)
    );

    apb_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .PCLK   (pclk),
        .PRESET (preset_n),
        .bus    (bus_ws2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hard stop in case a sequence never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, required finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One full APB transfer on instance inst: setup cycle, then access cycles
    // until PREADY (bounded). Checks the access cycle in which PREADY rose,
    // PSLVERR, and PRDATA for reads. Returns at the falling edge of the
    // completing cycle with PSEL/PENABLE still asserted, so a following call
    // issues a back-to-back setup.
    task automatic apply_stimulus(input int inst, input logic wr, input logic [7:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input int exp_cyc, input logic exp_err,
                                  input logic [31:0] exp_rdata, input string tag);
        int          cyc;
        logic        got_err;
        logic [31:0] got_rdata;
        @(posedge pclk); #1;
        psel_v       = 3'b000;
        psel_v[inst] = 1'b1;
        penable      = 1'b0;
        pwrite       = wr;
        paddr        = addr;
        pwdata       = wdata;
        pstrb        = strb;
        @(posedge pclk); #1;
        penable   = 1'b1;
        cyc       = 0;
        got_err   = 1'b0;
        got_rdata = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge pclk);
            if (rdy_v[inst]) begin
                cyc       = n;
                got_err   = err_v[inst];
                got_rdata = rdata_v[inst];
                break;
            end
        end
        check_output({tag, "_ready_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_output({tag, "_pslverr"}, 32'(got_err), 32'(exp_err));
        if (!wr) begin
            check_output({tag, "_prdata"}, got_rdata, exp_rdata);
        end
    endtask

    // Return the bus to idle after the current cycle ends.
    task automatic bus_idle();
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    // Assert reset between clock edges and check the instance outputs clear
    // immediately, then release on the next rising edge.
    task automatic reset_mid_cycle(input int inst, input string tag);
        #2;
        preset_n = 1'b0;
        #1;
        check_output({tag, "_pready"}, 32'(rdy_v[inst]), 32'd0);
        check_output({tag, "_pslverr"}, 32'(err_v[inst]), 32'd0);
        check_output({tag, "_prdata"}, rdata_v[inst], 32'd0);
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
    endtask

    initial begin
        int seen_ready;

        preset_n = 1'b0;
        psel_v   = 3'b000;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        pstrb    = '0;

        repeat (3) @(posedge pclk);
        #1;
        check_output("reset_pready", 32'(rdy_v), 32'd0);
        check_output("reset_pslverr", 32'(err_v), 32'd0);
        check_output("reset_prdata_ws0", rdata_v[0], 32'd0);
        check_output("reset_prdata_ws3", rdata_v[1], 32'd0);
        preset_n = 1'b1;

        $display("[TB] zero-wait write/read");
        apply_stimulus(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 1, APB_ERR_NONE, 32'h0, "ws0_wr08");
        apply_stimulus(0, 1'b0, 8'h08, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'hDEADBEEF, "ws0_rd08");

        $display("[TB] byte strobes");
        apply_stimulus(0, 1'b1, 8'h0C, 32'h11223344, 4'hF, 1, APB_ERR_NONE, 32'h0, "ws0_wr0c_full");
        apply_stimulus(0, 1'b1, 8'h0C, 32'hAABBCCDD, 4'b0101, 1, APB_ERR_NONE, 32'h0, "ws0_wr0c_strb");
        apply_stimulus(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'h11BB33DD, "ws0_rd0c_strb");
        apply_stimulus(0, 1'b1, 8'h0C, 32'hFFFFFFFF, 4'h0, 1, APB_ERR_NONE, 32'h0, "ws0_wr0c_nostrb");
        apply_stimulus(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'h11BB33DD, "ws0_rd0c_nostrb");
        bus_idle();

        $display("[TB] address errors and boundaries");
        apply_stimulus(0, 1'b0, 8'h80, 32'h0, 4'h0, 1, APB_ERR_ADDR, 32'h0, "ws0_rd80_range");
        apply_stimulus(0, 1'b1, 8'h00, 32'h0BADF00D, 4'hF, 1, APB_ERR_NONE, 32'h0, "ws0_wr00");
        apply_stimulus(0, 1'b1, 8'h02, 32'hCAFEBABE, 4'hF, 1, APB_ERR_ADDR, 32'h0, "ws0_wr02_misalign");
        apply_stimulus(0, 1'b0, 8'h00, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'h0BADF00D, "ws0_rd00_after_err");
        apply_stimulus(0, 1'b1, 8'h7C, 32'h77777777, 4'hF, 1, APB_ERR_NONE, 32'h0, "ws0_wr7c_last");
        apply_stimulus(0, 1'b0, 8'h7C, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'h77777777, "ws0_rd7c_last");
        apply_stimulus(0, 1'b0, 8'hFC, 32'h0, 4'h0, 1, APB_ERR_ADDR, 32'h0, "ws0_rdfc_range");
        apply_stimulus(0, 1'b0, 8'h01, 32'h0, 4'h0, 1, APB_ERR_ADDR, 32'h0, "ws0_rd01_misalign");
        bus_idle();

        $display("[TB] three wait states");
        apply_stimulus(1, 1'b1, 8'h04, 32'h5A5AA5A5, 4'hF, 4, APB_ERR_NONE, 32'h0, "ws3_wr04");
        apply_stimulus(1, 1'b0, 8'h04, 32'h0, 4'h0, 4, APB_ERR_NONE, 32'h5A5AA5A5, "ws3_rd04");
        bus_idle();

        $display("[TB] aborted write with two wait states");
        apply_stimulus(2, 1'b1, 8'h10, 32'h12345678, 4'hF, 3, APB_ERR_NONE, 32'h0, "ws2_wr10");
        bus_idle();
        @(posedge pclk); #1;
        psel_v  = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check_output("ws2_abort_acc1_pready", 32'(rdy_v[2]), 32'd0);
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        seen_ready = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge pclk);
            if (rdy_v[2]) seen_ready++;
        end
        check_output("ws2_abort_no_pready", 32'(seen_ready), 32'd0);
        apply_stimulus(2, 1'b0, 8'h10, 32'h0, 4'h0, 3, APB_ERR_NONE, 32'h12345678, "ws2_rd10_after_abort");
        bus_idle();

        $display("[TB] reset during wait states");
        @(posedge pclk); #1;
        psel_v  = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h04;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        reset_mid_cycle(1, "ws3_rst_wait");
        apply_stimulus(1, 1'b0, 8'h04, 32'h0, 4'h0, 4, APB_ERR_NONE, 32'h5A5AA5A5, "ws3_rd04_after_rst");
        bus_idle();

        $display("[TB] reset while completing");
        apply_stimulus(0, 1'b0, 8'h08, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'hDEADBEEF, "ws0_rd08_pre_rst");
        reset_mid_cycle(0, "ws0_rst_done_rd");
        apply_stimulus(0, 1'b0, 8'h84, 32'h0, 4'h0, 1, APB_ERR_ADDR, 32'h0, "ws0_rd84_pre_rst");
        reset_mid_cycle(0, "ws0_rst_done_err");
        apply_stimulus(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1, APB_ERR_NONE, 32'h11BB33DD, "ws0_rd0c_after_rst");
        bus_idle();

        repeat (2) @(posedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- Parametrised APB4-style completer fronting a byte-enabled register-file memory. It is the next generation of the team's 8-bit APB memory slave.
- Adds configurable data width, depth and wait states, plus PSTRB byte strobes and PSLVERR error response.
- Sits on the APB segment behind the bridge; one PSEL per instance.

Parameters:
- ADDR_W, 8, PADDR width in bits (byte address).
- DATA_W, 32, PWDATA/PRDATA width; must be 8, 16, 32 or 64.
- DEPTH, 32, number of DATA_W-bit words; need not be a power of two.
- WAIT_STATES, 0, access-phase cycles with PREADY=0 before completion; range 0..15.

Ports:
- PCLK  in  1  bus clock; all state changes on rising edge.
- PRESET  in  1  reset; asynchronous assert, active-low, synchronous deassert by upstream.
- PSEL  in  1  slave select.
- PADDR  in  ADDR_W  byte address.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  write byte strobes; ignored on reads.
- PRDATA  out  DATA_W  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion, registered.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=0, any time, including mid-transfer): state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0. Memory contents are not reset and are undefined until written.
- Definitions:
  - BYTE_SH = log2(DATA_W/8).
  - Word index = PADDR >> BYTE_SH.
  - Address error when the index is >= DEPTH, or when PADDR[BYTE_SH-1:0] != 0 (misaligned; not applicable when DATA_W=8).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - PSEL=1 & PENABLE=0 (setup): load cnt=WAIT_STATES.
  - If WAIT_STATES=0, go DONE. Otherwise go WAIT.
  - All other input combinations: stay IDLE.
- WAIT:
  - PSEL=1 & PENABLE=1: decrement cnt; when cnt reaches 1 -> DONE.
  - PSEL=0 (master abort / protocol violation): -> IDLE, no memory side effect.
- Entry into DONE: PREADY, PSLVERR and PRDATA are computed at the edge that enters DONE, from the PADDR, PWRITE, PWDATA and PSTRB sampled at that edge.
  - Read, no error: PRDATA = mem[index].
  - Read with error: PRDATA=0, PSLVERR=1.
  - Write, no error: PRDATA=0; commit is done at the DONE-exit edge.
  - Write with error: PSLVERR=1, no write.
- DONE (PREADY=1 for exactly one cycle):
  - At the exiting edge, a write with no error updates mem[index] byte-lane k only where PSTRB[k]=1. PSTRB=0 is a legal no-op write.
  - Next state: PSEL=1 & PENABLE=0 (back-to-back setup) -> behave as IDLE setup in that same edge. Otherwise -> IDLE.
  - On exit: PREADY=0, PSLVERR=0, PRDATA=0.
- Latency: the transfer completes in access cycle WAIT_STATES+1, counting the first PENABLE=1 cycle as 1.
  - Zero-wait: setup + one access cycle.
  - Back-to-back transfers: 2+WAIT_STATES cycles each.
- Read-after-write to the same word in the next transfer returns the updated data (write commits before the next DONE entry).
- PADDR width larger than needed: upper bits participate in the range check; no aliasing.

Decomposition:
- Shared package apb_pkg:
  - typedef enum apb_slv_state_t {IDLE, WAIT, DONE}.
  - Localparam helpers for BYTE_SH and strobe width.
  - Constant APB_ERR_NONE/APB_ERR_ADDR for the bench scoreboard.
- One sub-module apb_sram_bank (parameters DATA_W, DEPTH):
  - Synchronous byte-enabled write port.
  - Combinational read port.
  - Keeps the memory array separate from the FSM for later SRAM macro swap.

Test Plan:
- DATA_W=32, WAIT_STATES=0, PSTRB=4'hF: write 0xDEADBEEF to PADDR 0x08 then read 0x08 -> PREADY high in 1st access cycle both times, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0x11223344 strobe 4'hF, then 0xAABBCCDD strobe 4'b0101, then read -> PRDATA=0x11BB33DD.
- WAIT_STATES=3: single read -> PREADY=0 for access cycles 1-3 and 1 in cycle 4; PRDATA valid only in cycle 4.
- Errors, DEPTH=32, DATA_W=32:
  - Read PADDR 0x80 -> PSLVERR=1, PRDATA=0.
  - Write 0x02 (misaligned) -> PSLVERR=1, and a later read of 0x00 shows no change.
- Abort: WAIT_STATES=2, drop PSEL after first access cycle of a write -> FSM to IDLE, PREADY never asserted, memory unchanged.
- Reset mid-transfer: assert PRESET=0 during WAIT -> PREADY/PSLVERR/PRDATA=0 immediately (before next PCLK edge); next transfer after release completes normally.
